tlb_miss_ctrl: RTL
==================

Name: tlb_miss_ctrl

Overview:
- Sequencing controller in front of the set-associative TLB (`cache`). Takes one translation request at a time from a requester over valid/ready.
- Drives the TLB lookup. On a hit, returns the physical address.
- On a miss, issues a page-walk request, inserts the walked PA into the TLB with a one-cycle insert pulse, then responds.
- Sits between the core-side requester, the TLB and the page-table walker.

Parameters:
- VA_W, 64, virtual address width
- PA_W, 64, physical address width
- PCID_W, 12, process-context ID width
- TLB_LAT, 1, cycles from driving tlb_va/tlb_pcid to valid tlb_hit/tlb_miss/tlb_addr (1..7)
- WALK_TIMEOUT, 1023, maximum cycles in WALK_WAIT before a fault is reported (1..65535)

Ports:
- clk  in  1  clock, rising edge
- shutdown  in  1  asynchronous, active-high reset
- req_valid  in  1  translation request valid
- req_ready  out  1  controller can accept a request
- req_va  in  VA_W  virtual address
- req_pcid  in  PCID_W  PCID of the request
- resp_valid  out  1  response valid
- resp_ready  in  1  requester accepts the response
- resp_pa  out  PA_W  translated physical address
- resp_fault  out  1  translation failed
- tlb_va  out  VA_W  lookup/insert VA to the TLB
- tlb_pcid  out  PCID_W  lookup/insert PCID to the TLB
- tlb_pa  out  PA_W  PA to insert
- tlb_insert  out  1  one-cycle insert strobe
- tlb_hit  in  1  TLB hit
- tlb_miss  in  1  TLB miss
- tlb_addr  in  PA_W  TLB output address
- walk_req_valid  out  1  walk request valid
- walk_req_ready  in  1  walker accepts the request
- walk_va  out  VA_W  VA to walk
- walk_pcid  out  PCID_W  PCID to walk
- walk_resp_valid  in  1  walk result, single-cycle pulse
- walk_resp_pa  in  PA_W  walked PA
- walk_resp_fault  in  1  walk fault

Behaviour:
- Reset (shutdown=1, async): state IDLE; all outputs 0 except req_ready=1; counters and stale flag cleared. Reset mid-operation abandons the transaction and raises no insert.
- States: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, INSERT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register va and pcid, load lat_cnt=TLB_LAT, go to LOOKUP.
  - tlb_va, tlb_pcid, walk_va and walk_pcid hold the registered values until the next accept.
- LOOKUP:
  - lat_cnt decrements each cycle; results are sampled in the cycle lat_cnt==1.
  - tlb_hit=1: resp_pa=tlb_addr, resp_fault=0, go to RESP. Hit wins if hit and miss are both 1.
  - Otherwise (miss, or neither asserted): go to WALK_REQ.
  - Request-to-response latency on a hit is TLB_LAT+1 cycles.
- WALK_REQ:
  - walk_req_valid=1, held until walk_req_ready; then go to WALK_WAIT with to_cnt=0.
  - No timeout in this state.
- WALK_WAIT:
  - to_cnt increments each cycle.
  - On walk_resp_valid with fault=0: tlb_pa=walk_resp_pa, resp_pa=walk_resp_pa, go to INSERT.
  - On walk_resp_valid with fault=1: resp_fault=1, resp_pa=0, go to RESP with no insert.
  - If to_cnt reaches WALK_TIMEOUT before a response: resp_fault=1, resp_pa=0, set stale, go to RESP.
- INSERT: tlb_insert=1 for exactly one cycle, then go to RESP.
- RESP:
  - resp_valid=1, with resp_pa and resp_fault held stable until resp_ready.
  - After the handshake, go to IDLE and clear resp_valid.
  - req_ready is 0 in every state other than IDLE, so the earliest next accept is the cycle after the handshake.
- Stale flag: while set, the next walk_resp_valid seen in any state is discarded and clears the flag. A discarded response produces no insert and no response.
- walk_resp_valid outside WALK_WAIT with stale=0 is ignored.

Optional Feature:
- Macro: TLB_MISS_CTRL_STATS_EN.
- Defined: adds output ports stat_hits, stat_misses and stat_faults, each 32 bits.
  - Counters are saturating and reset to 0.
  - stat_hits increments on a LOOKUP hit. stat_misses increments on LOOKUP→WALK_REQ. stat_faults increments on a walk fault or a timeout.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Hit path: TLB_LAT=1, req va=64'hffff_ffff_ffff_fff1, pcid=0; TLB returns hit with addr=64'h1000 → resp_valid 2 cycles after accept, resp_pa=64'h1000, resp_fault=0, no walk_req_valid, no tlb_insert.
- Miss path: same va, pcid=1, tlb_miss=1; walker accepts and returns pa=64'h2000 → walk_pcid=1, one tlb_insert pulse with tlb_va=va, tlb_pcid=1, tlb_pa=64'h2000; resp_pa=64'h2000.
- Walk fault: walk_resp_fault=1 → resp_fault=1, resp_pa=0, tlb_insert never asserted.
- Timeout: WALK_TIMEOUT=8 with no walk response → resp_fault=1 after 8 cycles in WALK_WAIT. A later walk_resp_valid (pa=64'h3000) is discarded: no insert and no response. The next request then completes normally.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid and resp_pa stable and req_ready=0 throughout; walk_req_ready=0 for 4 cycles → walk_req_valid held with walk_va stable.
- Reset mid-walk: shutdown pulsed in WALK_WAIT → all outputs 0 immediately (req_ready=1 after reset); no insert and no response; a subsequent request hits normally.

Source files
------------

// File: rtl/tlb_miss_ctrl.sv
// TLB miss sequencer: lookup, page-walk on miss, insert walked PA, respond.
// Optional hit/miss/fault counters enabled by defining TLB_MISS_CTRL_STATS_EN.
module tlb_miss_ctrl #(
    parameter int VA_W         = 64,
    parameter int PA_W         = 64,
    parameter int PCID_W       = 12,
    parameter int TLB_LAT      = 1,
    parameter int WALK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              shutdown,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VA_W-1:0]   req_va,
    input  logic [PCID_W-1:0] req_pcid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [PA_W-1:0]   resp_pa,
    output logic              resp_fault,
    output logic [VA_W-1:0]   tlb_va,
    output logic [PCID_W-1:0] tlb_pcid,
    output logic [PA_W-1:0]   tlb_pa,
    output logic              tlb_insert,
    input  logic              tlb_hit,
    input  logic              tlb_miss,
    input  logic [PA_W-1:0]   tlb_addr,
    output logic              walk_req_valid,
    input  logic              walk_req_ready,
    output logic [VA_W-1:0]   walk_va,
    output logic [PCID_W-1:0] walk_pcid,
    input  logic              walk_resp_valid,
    input  logic [PA_W-1:0]   walk_resp_pa,
    input  logic              walk_resp_fault
`ifdef TLB_MISS_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_faults
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK_REQ,
        WALK_WAIT,
        INSERT,
        RESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(WALK_TIMEOUT - 1);

    state_t            state_q;
    logic [2:0]        lat_cnt_q;
    logic [15:0]       to_cnt_q;
    logic              stale_q;
    logic [VA_W-1:0]   va_q;
    logic [PCID_W-1:0] pcid_q;
    logic [PA_W-1:0]   resp_pa_q;
    logic              resp_fault_q;
    logic              resp_valid_q;
    logic              req_ready_q;
    logic [PA_W-1:0]   tlb_pa_q;
    logic              tlb_insert_q;
    logic              walk_req_valid_q;

    // A response arriving while stale belongs to an abandoned walk.
    logic stale_drop;
    logic walk_ok;
    logic lookup_done;
    logic to_expire;
    logic unused_miss;

    assign stale_drop  = walk_resp_valid & stale_q;
    assign walk_ok     = walk_resp_valid & ~stale_q;
    assign lookup_done = (state_q == LOOKUP) && (lat_cnt_q == 3'd1);
    assign to_expire   = (state_q == WALK_WAIT) && !walk_ok
                         && (to_cnt_q == TO_LAST);
    // Anything but a hit triggers a walk, so the miss strobe is redundant.
    assign unused_miss = tlb_miss;

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_pa        = resp_pa_q;
    assign resp_fault     = resp_fault_q;
    assign tlb_va         = va_q;
    assign tlb_pcid       = pcid_q;
    assign tlb_pa         = tlb_pa_q;
    assign tlb_insert     = tlb_insert_q;
    assign walk_req_valid = walk_req_valid_q;
    assign walk_va        = va_q;
    assign walk_pcid      = pcid_q;

    // Main sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge shutdown) begin
        if (shutdown) begin
            state_q          <= IDLE;
            lat_cnt_q        <= '0;
            to_cnt_q         <= '0;
            stale_q          <= 1'b0;
            va_q             <= '0;
            pcid_q           <= '0;
            resp_pa_q        <= '0;
            resp_fault_q     <= 1'b0;
            resp_valid_q     <= 1'b0;
            req_ready_q      <= 1'b1;
            tlb_pa_q         <= '0;
            tlb_insert_q     <= 1'b0;
            walk_req_valid_q <= 1'b0;
        end else begin
            tlb_insert_q <= 1'b0;
            if (stale_drop) begin
                stale_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        va_q        <= req_va;
                        pcid_q      <= req_pcid;
                        lat_cnt_q   <= 3'(TLB_LAT);
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    lat_cnt_q <= lat_cnt_q - 3'd1;
                    if (lookup_done) begin
                        if (tlb_hit) begin
                            resp_pa_q    <= tlb_addr;
                            resp_fault_q <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            walk_req_valid_q <= 1'b1;
                            state_q          <= WALK_REQ;
                        end
                    end
                end
                WALK_REQ: begin
                    if (walk_req_ready) begin
                        walk_req_valid_q <= 1'b0;
                        to_cnt_q         <= '0;
                        state_q          <= WALK_WAIT;
                    end
                end
                WALK_WAIT: begin
                    to_cnt_q <= to_cnt_q + 16'd1;
                    if (walk_ok) begin
                        if (walk_resp_fault) begin
                            resp_pa_q    <= '0;
                            resp_fault_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            tlb_pa_q     <= walk_resp_pa;
                            resp_pa_q    <= walk_resp_pa;
                            resp_fault_q <= 1'b0;
                            tlb_insert_q <= 1'b1;
                            state_q      <= INSERT;
                        end
                    end else if (to_expire) begin
                        resp_pa_q    <= '0;
                        resp_fault_q <= 1'b1;
                        resp_valid_q <= 1'b1;
                        stale_q      <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                INSERT: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TLB_MISS_CTRL_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic [31:0] faults_q;
    logic        hit_ev;
    logic        miss_ev;
    logic        fault_ev;

    assign hit_ev   = lookup_done && tlb_hit;
    assign miss_ev  = lookup_done && !tlb_hit;
    assign fault_ev = ((state_q == WALK_WAIT) && walk_ok && walk_resp_fault)
                      || to_expire;

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_faults = faults_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge shutdown) begin
        if (shutdown) begin
            hits_q   <= '0;
            misses_q <= '0;
            faults_q <= '0;
        end else begin
            if (hit_ev && (hits_q != '1)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (miss_ev && (misses_q != '1)) begin
                misses_q <= misses_q + 32'd1;
            end
            if (fault_ev && (faults_q != '1)) begin
                faults_q <= faults_q + 32'd1;
            end
        end
    end
`endif

endmodule
